// File: rtl/uart_tx_fifo.sv
// UART transmitter with an integrated transmit FIFO.
// Build-time data width, FIFO depth and divisor width. The baud divisor,
// parity mode and stop-bit count are sampled when each frame is popped.
// Frames go out back-to-back while the FIFO holds data.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                            clk_i,
    input  logic                            reset_n,
    input  logic [DIV_W-1:0]                baud_div_i,
    input  logic [1:0]                      parity_i,
    input  logic                            stop2_i,
    input  logic [DATA_BITS-1:0]            wr_data_i,
    input  logic                            wr_en_i,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [$clog2(FIFO_DEPTH):0]     level_o,
    output logic                            overflow_o,
    output logic                            busy_o,
    output logic                            uart_tx_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]        count_q;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    // Frame engine
    state_t               state_q, state_d;
    logic                 load;
    logic                 tx_q, tx_d;
    logic [DIV_W-1:0]     timer_q, div_q, div_eff;
    logic [BW-1:0]        bit_q;
    logic                 stop_q;
    logic [DATA_BITS-1:0] shreg_q;
    logic                 par_en_q, par_bit_q, stop2_q;
    logic                 bit_end;

    assign full_o     = (count_q == LW'(FIFO_DEPTH));
    assign empty_o    = (count_q == '0);
    assign level_o    = count_q;
    assign busy_o     = (state_q != S_IDLE) || !empty_o;
    assign uart_tx_o  = tx_q;

    // A full FIFO drops the write even if a pop frees a slot this cycle.
    assign push    = wr_en_i && !full_o;
    assign head    = mem[rd_ptr_q];
    assign div_eff = (baud_div_i == '0) ? DIV_W'(1) : baud_div_i;
    assign bit_end = (timer_q == DIV_W'(1));

    // FIFO storage write (no reset needed on the data array)
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= wr_data_i;
    end

    // FIFO pointers, occupancy and overflow pulse
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= wr_en_i && full_o;
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + LW'(1);
                2'b01:   count_q <= count_q - LW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state; load marks the start of a new bit, pop a new frame
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        unique case (state_q)
            S_IDLE: if (!empty_o) begin
                pop = 1'b1; load = 1'b1; state_d = S_START;
            end
            S_START: if (bit_end) begin
                load = 1'b1; state_d = S_DATA;
            end
            S_DATA: if (bit_end) begin
                load = 1'b1;
                if (bit_q == BW'(DATA_BITS - 1))
                    state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: if (bit_end) begin
                load = 1'b1; state_d = S_STOP;
            end
            S_STOP: if (bit_end) begin
                if (stop2_q && !stop_q) begin
                    load = 1'b1;
                end else if (!empty_o) begin
                    pop = 1'b1; load = 1'b1; state_d = S_START;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM output: next line level, taken at each bit start
    always_comb begin
        tx_d = tx_q;
        if (state_d == S_IDLE) tx_d = 1'b1;
        else if (load) begin
            unique case (state_d)
                S_START:  tx_d = 1'b0;
                S_DATA:   tx_d = shreg_q[0];
                S_PARITY: tx_d = par_bit_q;
                default:  tx_d = 1'b1;
            endcase
        end
    end

    // Line register: the only driver of uart_tx_o
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) tx_q <= 1'b1;
        else          tx_q <= tx_d;
    end

    // Bit timer, bit counters, shift register and per-frame config
    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            timer_q   <= '0;
            div_q     <= DIV_W'(1);
            bit_q     <= '0;
            stop_q    <= 1'b0;
            shreg_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
        end else begin
            if (load)                     timer_q <= pop ? div_eff : div_q;
            else if (state_q != S_IDLE)   timer_q <= timer_q - DIV_W'(1);

            if (pop) begin
                shreg_q   <= head;
                div_q     <= div_eff;
                stop2_q   <= stop2_i;
                par_en_q  <= (parity_i == 2'b01) || (parity_i == 2'b10);
                par_bit_q <= (parity_i == 2'b01) ? ~(^head) : ^head;
            end else if (load && state_d == S_DATA) begin
                shreg_q <= shreg_q >> 1;
            end

            if (load) begin
                if (state_q == S_START)     bit_q <= '0;
                else if (state_q == S_DATA) bit_q <= bit_q + BW'(1);
                stop_q <= (state_q == S_STOP) && (state_d == S_STOP);
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a default-size instance and a 5-bit/4-deep one.
// Expected frames are queued as words are written; a line monitor per
// instance pops them and checks the serial waveform cycle by cycle.
module tb_uart_tx_fifo;

    typedef struct {
        logic [15:0] bits;
        int          nb;
        int          div;
    } exp_t;

    typedef struct {
        logic [15:0] div;
        logic [1:0]  par;
        logic        s2;
        logic [7:0]  data;
        int          len;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    logic [15:0] div0 = '0, div1 = '0;
    logic [1:0]  par0 = '0, par1 = '0;
    logic        st0 = 1'b0, st1 = 1'b0;
    logic [7:0]  wd0 = '0;
    logic [4:0]  wd1 = '0;
    logic        we0 = 1'b0, we1 = 1'b0;
    logic        full0, empty0, ovf0, busy0, tx0;
    logic        full1, empty1, ovf1, busy1, tx1;
    logic [4:0]  level0;
    logic [2:0]  level1;

    int vectors = 0, miscompares = 0;
    int frames0 = 0, frames1 = 0;
    exp_t q0[$], q1[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(16), .DIV_W(16)) u_dut (
        .clk_i(clk), .reset_n(reset_n), .baud_div_i(div0), .parity_i(par0),
        .stop2_i(st0), .wr_data_i(wd0), .wr_en_i(we0), .full_o(full0),
        .empty_o(empty0), .level_o(level0), .overflow_o(ovf0), .busy_o(busy0),
        .uart_tx_o(tx0));

    uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(4), .DIV_W(16)) u_small (
        .clk_i(clk), .reset_n(reset_n), .baud_div_i(div1), .parity_i(par1),
        .stop2_i(st1), .wr_data_i(wd1), .wr_en_i(we1), .full_o(full1),
        .empty_o(empty1), .level_o(level1), .overflow_o(ovf1), .busy_o(busy1),
        .uart_tx_o(tx1));

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional parity, stop 1s.
    function automatic exp_t mk(input logic [8:0] d, input int db, input logic [1:0] p,
                                input logic s2, input logic [15:0] dv);
        exp_t e;
        int   n;
        logic pb;
        e.bits = '1;
        e.bits[0] = 1'b0;
        n = 1;
        pb = 1'b0;
        for (int i = 0; i < db; i++) begin
            e.bits[n] = d[i];
            pb ^= d[i];
            n++;
        end
        if (p == 2'b01 || p == 2'b10) begin
            e.bits[n] = (p == 2'b01) ? ~pb : pb;
            n++;
        end
        n += s2 ? 2 : 1;
        e.nb  = n;
        e.div = (dv == 0) ? 1 : int'(dv);
        return e;
    endfunction

    function automatic logic line_of(input int sel);
        return (sel == 0) ? tx0 : tx1;
    endfunction

    // Called at the negedge where a start bit is first seen.
    task automatic run_frame(input int sel);
        exp_t e;
        logic got;
        int   guard;
        if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
            check($sformatf("dut%0d_unexpected_frame", sel), 1, 0);
            guard = 0;
            while (line_of(sel) == 1'b0 && guard < 1000) begin
                guard++;
                @(negedge clk);
            end
            return;
        end
        e = (sel == 0) ? q0.pop_front() : q1.pop_front();
        for (int b = 0; b < e.nb; b++) begin
            got = e.bits[b];
            for (int c = 0; c < e.div; c++) begin
                if (b > 0 || c > 0) @(negedge clk);
                if (!reset_n) return;
                if (line_of(sel) !== e.bits[b]) got = line_of(sel);
            end
            check($sformatf("dut%0d_bit%0d", sel, b), got, e.bits[b]);
        end
        if (sel == 0) frames0++;
        else          frames1++;
    endtask

    always begin
        @(negedge clk);
        if (reset_n && tx0 === 1'b0) run_frame(0);
    end

    always begin
        @(negedge clk);
        if (reset_n && tx1 === 1'b0) run_frame(1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[6];
        int   cnt;
        logic stayed_high;

        vt[0] = '{div: 16'd4, par: 2'b00, s2: 1'b0, data: 8'h55, len: 40};
        vt[1] = '{div: 16'd3, par: 2'b10, s2: 1'b1, data: 8'h07, len: 36};
        vt[2] = '{div: 16'd1, par: 2'b01, s2: 1'b0, data: 8'hA5, len: 11};
        vt[3] = '{div: 16'd0, par: 2'b11, s2: 1'b1, data: 8'hFF, len: 11};
        vt[4] = '{div: 16'd5, par: 2'b01, s2: 1'b1, data: 8'h00, len: 60};
        vt[5] = '{div: 16'd2, par: 2'b10, s2: 1'b0, data: 8'h80, len: 22};

        // Reset state, asserted asynchronously before any clock edge
        #2 reset_n = 1'b0;
        #1;
        check("rst_tx", tx0, 1);
        check("rst_level", level0, 0);
        check("rst_empty", empty0, 1);
        check("rst_full", full0, 0);
        check("rst_ovf", ovf0, 0);
        check("rst_busy", busy0, 0);
        check("rst_small_tx", tx1, 1);
        check("rst_small_level", level1, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Single frames across configurations; config is scrambled mid-frame
        for (int v = 0; v < 6; v++) begin
            div0 = vt[v].div; par0 = vt[v].par; st0 = vt[v].s2;
            wd0 = vt[v].data; we0 = 1'b1;
            q0.push_back(mk({1'b0, vt[v].data}, 8, vt[v].par, vt[v].s2, vt[v].div));
            @(negedge clk);
            we0 = 1'b0;
            check($sformatf("v%0d_level_after_write", v), level0, 1);
            cnt = 0;
            while (busy0 && cnt < 5000) begin
                if (cnt == 3) begin
                    div0 = 16'd7; par0 = ~vt[v].par; st0 = ~vt[v].s2;
                end
                cnt++;
                @(negedge clk);
            end
            check($sformatf("v%0d_busy_cycles", v), cnt, vt[v].len + 1);
            check($sformatf("v%0d_empty", v), empty0, 1);
        end

        // Three back-to-back frames at div=2, 8N1: no idle gap between them
        div0 = 16'd2; par0 = 2'b00; st0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wd0 = 8'h31 + 8'(i * 16); we0 = 1'b1;
            q0.push_back(mk({1'b0, wd0}, 8, 2'b00, 1'b0, 16'd2));
            @(negedge clk);
            check($sformatf("b2b_level_w%0d", i), level0, (i == 2) ? 2 : 1);
        end
        we0 = 1'b0;
        cnt = 0;
        while (busy0 && cnt < 5000) begin
            if (cnt == 19) check("b2b_level_after_pop2", level0, 1);
            if (cnt == 39) check("b2b_level_after_pop3", level0, 0);
            cnt++;
            @(negedge clk);
        end
        check("b2b_busy_cycles", cnt, 59);

        // Reset mid-data-bit with words still queued
        div0 = 16'd4; par0 = 2'b00; st0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wd0 = 8'hC3 ^ 8'(i); we0 = 1'b1;
            q0.push_back(mk({1'b0, wd0}, 8, 2'b00, 1'b0, 16'd4));
            @(negedge clk);
        end
        we0 = 1'b0;
        repeat (14) @(negedge clk);
        #2 reset_n = 1'b0;
        q0.delete();
        #1;
        check("midrst_tx_immediate", tx0, 1);
        check("midrst_level_immediate", level0, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stayed_high = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx0 !== 1'b1) stayed_high = 1'b0;
        end
        check("midrst_line_idle", stayed_high, 1);
        check("midrst_level", level0, 0);
        check("midrst_busy", busy0, 0);
        check("midrst_empty", empty0, 1);

        // 5O1 with divisor 0: one cycle per bit, 8-cycle frame, parity 0
        div1 = 16'd0; par1 = 2'b01; st1 = 1'b0;
        wd1 = 5'h1F; we1 = 1'b1;
        q1.push_back(mk({4'b0, wd1}, 5, 2'b01, 1'b0, 16'd0));
        @(negedge clk);
        we1 = 1'b0;
        cnt = 0;
        while (busy1 && cnt < 5000) begin
            cnt++;
            @(negedge clk);
        end
        check("d5_busy_cycles", cnt, 9);

        // Depth-4 FIFO: six consecutive writes, sixth dropped
        div1 = 16'd100; par1 = 2'b00; st1 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            wd1 = 5'(i + 3); we1 = 1'b1;
            if (i < 5) q1.push_back(mk({4'b0, wd1}, 5, 2'b00, 1'b0, 16'd100));
            @(negedge clk);
            if (i == 4) begin
                check("ovf_full", full1, 1);
                check("ovf_level_full", level1, 4);
                check("ovf_no_pulse_yet", ovf1, 0);
            end
            if (i == 5) check("ovf_pulse", ovf1, 1);
        end
        we1 = 1'b0;
        @(negedge clk);
        check("ovf_pulse_one_cycle", ovf1, 0);
        cnt = 0;
        while (busy1 && cnt < 8000) begin
            cnt++;
            @(negedge clk);
        end
        check("ovf_drained", busy1, 0);
        check("ovf_frames", frames1, 6);
        check("small_queue_empty", q1.size(), 0);

        check("main_frames", frames0, 9);
        check("main_queue_empty", q0.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter with an integrated transmit FIFO. It replaces the fixed 8N1, fixed-divider transmitter. Data width, FIFO depth and divider width are set at build time. Baud divisor, parity mode and stop-bit count are set at run time. It sits between the CPU/bus write port and the board TX pin, and sends back-to-back frames with no idle gap while the FIFO holds data.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; transmitted LSB first.
FIFO_DEPTH, 16, number of FIFO entries; must be a power of 2 and at least 2.
DIV_W, 16, width of the runtime baud divisor.

Ports:
clk_i  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
baud_div_i  in  DIV_W  clock cycles per bit; value 0 is treated as 1.
parity_i  in  2  parity mode: 00 none, 01 odd, 10 even, 11 none.
stop2_i  in  1  0 = one stop bit, 1 = two stop bits.
wr_data_i  in  DATA_BITS  word to enqueue.
wr_en_i  in  1  enqueue strobe, one word per cycle.
full_o  out  1  FIFO holds FIFO_DEPTH words.
empty_o  out  1  FIFO holds 0 words.
level_o  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
overflow_o  out  1  one-cycle pulse when a write is dropped.
busy_o  out  1  FSM not in IDLE, or FIFO not empty.
uart_tx_o  out  1  serial output; idles high.

Behaviour:
- Reset (asynchronous, active-low, takes effect immediately):
  - uart_tx_o=1, FSM=IDLE.
  - FIFO pointers cleared, level_o=0, empty_o=1, full_o=0.
  - overflow_o=0, busy_o=0.
  - Reset asserted mid-frame aborts the frame at once: line forced high, queued data discarded.
- FIFO writes:
  - A write with wr_en_i=1 and full_o=0 is stored on that clock edge; level_o rises by 1 after the edge.
  - wr_en_i=1 while full_o=1: word dropped, overflow_o=1 for the next cycle.
  - A write is dropped when full even if a pop happens in the same cycle.
  - Simultaneous accepted write and pop: level_o unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame configuration: baud_div_i, parity_i and stop2_i are latched when a frame starts (at the pop). Changes mid-frame do not affect the frame in flight.
- Bit timer: a down-counter loaded with max(baud_div_i,1) at each bit start. The bit ends when the count reaches 1, so every bit lasts exactly max(baud_div_i,1) cycles.
- FSM states and transitions:
  - IDLE: uart_tx_o=1. If FIFO not empty: pop the head into the shift register, latch the config, uart_tx_o<=0 on the same edge, go to START.
  - START: at bit end, drive data bit 0 and go to DATA.
  - DATA: a bit counter runs 0..DATA_BITS-1, shifting LSB first. After the last data bit ends:
    - go to PARITY, driving the parity bit, if parity is enabled;
    - otherwise go to STOP, driving 1.
  - PARITY: even mode sends XOR of the data bits; odd mode sends its inverse. At bit end, go to STOP driving 1.
  - STOP: lasts 1 or 2 bit times. At the end:
    - if the FIFO is not empty: pop, drive 0 on the same edge, go to START (no idle gap);
    - otherwise go to IDLE.
- Latency: a write into an empty FIFO at edge N is popped at edge N+1, so uart_tx_o is low from edge N+1.
- Frame length = (1 + DATA_BITS + P + S) × div cycles, where P = 0/1 (parity bit) and S = 1/2 (stop bits).
- busy_o deasserts on the same edge the FSM enters IDLE with the FIFO empty.
- uart_tx_o is driven from a register; no combinational path from inputs.

Test Plan:
- 8N1, div=4, write 0x55 -> line low 4 cycles; then bits 1,0,1,0,1,0,1,0 at 4 cycles each; stop high 4 cycles; busy_o high for 40 cycles after the pop.
- 8E2, div=3, write 0x07 -> data 1,1,1,0,0,0,0,0; parity bit 1; two stop bits of 3 cycles each; frame = 36 cycles.
- div=2, write 3 words back-to-back -> three contiguous 20-cycle frames; second start bit begins the cycle after the first stop bit ends; level_o sequence 1,2,1,0 with pops visible.
- FIFO_DEPTH=4, div=100, write 6 words in consecutive cycles -> first word popped after 1 cycle, 4 more stored, full_o=1, 6th write dropped with one overflow_o pulse; exactly 5 frames transmitted.
- Assert reset_n=0 mid-data-bit with 3 words queued -> uart_tx_o=1 immediately; after release, level_o=0, busy_o=0, no further frames.
- div=0 and DATA_BITS=5, 5O1, write 0x1F -> every bit lasts 1 cycle; parity bit 0; frame = 8 cycles.
